id_stage_pipe: RTL and testbench

Parametrised, pipelined instruction-decode stage for the 16-bit-encoding OpenCPU core. It extracts register fields and the immediate, reads an internal 8-entry register file with write-back bypass, and presents decoded operands through a registered ID/EX stage with a valid/ready handshake. Flush and stall are supported, and operands are refreshed in place while the stage is stalled. It sits between IF and EX and replaces the purely combinational decode path.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/id_stage_pipe_if.sv | 43 ++++
 rtl/id_regfile.sv | 48 ++++
 rtl/id_stage_pipe.sv | 122 ++++++++++++
 tb/tb_id_stage_pipe.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared OpenCPU constants and field helpers for the 16-bit instruction encoding.
// Field positions live here so decode and EX agree on one definition.
package cpu_pkg;

    localparam int INST_WIDTH = 16;
    localparam int REG_AW     = 3;
    localparam int REG_NUM    = 8;

    localparam int RD_LSB        = 5;
    localparam int RS_LSB        = 8;
    localparam int IMM_LONG_LSB  = 8;
    localparam int IMM_LONG_W    = 8;
    localparam int IMM_SHORT_LSB = 11;
    localparam int IMM_SHORT_W   = 5;

    typedef logic [REG_AW-1:0]     reg_addr_t;
    typedef logic [INST_WIDTH-1:0] inst_t;

    function automatic reg_addr_t rd_field(inst_t i);
        return i[RD_LSB +: REG_AW];
    endfunction

    function automatic reg_addr_t rs_field(inst_t i);
        return i[RS_LSB +: REG_AW];
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Bundle of the IF-side handshake, write-back port and ID/EX outputs of id_stage_pipe.
// The stage uses the slave modport; the driver of IF/WB/EX uses master.
interface id_stage_pipe_if #(
    parameter int CPU_WIDTH = 16
) ();
    import cpu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    inst_t                inst;
    logic                 imm_sel;
    logic                 flush;

    logic                 wb_we;
    reg_addr_t            wb_addr;
    logic [CPU_WIDTH-1:0] wb_data;

    logic                 out_valid;
    logic                 out_ready;
    reg_addr_t            out_rd_addr;
    reg_addr_t            out_rs_addr;
    logic [CPU_WIDTH-1:0] out_rd;
    logic [CPU_WIDTH-1:0] out_rs;
    logic [CPU_WIDTH-1:0] out_imm;
    inst_t                out_inst;

    modport slave (
        input  in_valid, inst, imm_sel, flush,
        input  wb_we, wb_addr, wb_data,
        input  out_ready,
        output in_ready,
        output out_valid, out_rd_addr, out_rs_addr, out_rd, out_rs, out_imm, out_inst
    );

    modport master (
        output in_valid, inst, imm_sel, flush,
        output wb_we, wb_addr, wb_data,
        output out_ready,
        input  in_ready,
        input  out_valid, out_rd_addr, out_rs_addr, out_rd, out_rs, out_imm, out_inst
    );

endinterface

// File: rtl/id_regfile.sv
// 8-entry register file, one write port and NUM_RD combinational read ports that
// forward same-cycle write-back data. Optional hardwired-zero r0.
module id_regfile
    import cpu_pkg::*;
#(
    parameter int CPU_WIDTH = 16,
    parameter bit R0_ZERO   = 1'b0,
    parameter int NUM_RD    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  reg_addr_t            waddr,
    input  logic [CPU_WIDTH-1:0] wdata,
    input  reg_addr_t            raddr [NUM_RD],
    output logic [CPU_WIDTH-1:0] rdata [NUM_RD],
    output logic                 wr_hit
);

    logic [CPU_WIDTH-1:0] mem_reg [REG_NUM];

    // A write to r0 is dropped entirely when r0 is hardwired, so it must not forward either.
    assign wr_hit = we && !(R0_ZERO && (waddr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_hit) begin
            mem_reg[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            always_comb begin
                rdata[gi] = mem_reg[raddr[gi]];
                if (R0_ZERO && (raddr[gi] == '0)) begin
                    rdata[gi] = '0;
                end else if (wr_hit && (waddr == raddr[gi])) begin
                    rdata[gi] = wdata;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: field extraction, immediate extension, bypassed register
// read and a valid/ready ID/EX register that refreshes its operands while stalled.
module id_stage_pipe
    import cpu_pkg::*;
#(
    parameter int CPU_WIDTH  = 16,
    parameter bit IMM_SIGNED = 1'b0,
    parameter bit R0_ZERO    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);

    reg_addr_t            rd_addr;
    reg_addr_t            rs_addr;
    reg_addr_t            rf_raddr [2];
    logic [CPU_WIDTH-1:0] rf_rdata [2];
    logic                 wb_hit;

    logic [CPU_WIDTH-1:0] imm_long;
    logic [CPU_WIDTH-1:0] imm_short;
    logic [CPU_WIDTH-1:0] imm_ext;
    logic                 ext_bit;

    logic                 in_ready;
    logic                 accept;

    logic                 out_valid_reg;
    reg_addr_t            out_rd_addr_reg;
    reg_addr_t            out_rs_addr_reg;
    logic [CPU_WIDTH-1:0] out_rd_reg;
    logic [CPU_WIDTH-1:0] out_rs_reg;
    logic [CPU_WIDTH-1:0] out_imm_reg;
    inst_t                out_inst_reg;

    assign rd_addr     = rd_field(bus.inst);
    assign rs_addr     = rs_field(bus.inst);
    assign rf_raddr[0] = rd_addr;
    assign rf_raddr[1] = rs_addr;

    id_regfile #(
        .CPU_WIDTH (CPU_WIDTH),
        .R0_ZERO   (R0_ZERO),
        .NUM_RD    (2)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_we),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data),
        .raddr  (rf_raddr),
        .rdata  (rf_rdata),
        .wr_hit (wb_hit)
    );

    // Both immediate forms end at inst[15], so one extension bit serves either width.
    assign ext_bit = IMM_SIGNED ? bus.inst[INST_WIDTH-1] : 1'b0;

    generate
        for (genvar gi = 0; gi < CPU_WIDTH; gi++) begin : g_imm
            if (gi < IMM_LONG_W) begin : g_long_field
                assign imm_long[gi] = bus.inst[IMM_LONG_LSB + gi];
            end else begin : g_long_ext
                assign imm_long[gi] = ext_bit;
            end
            if (gi < IMM_SHORT_W) begin : g_short_field
                assign imm_short[gi] = bus.inst[IMM_SHORT_LSB + gi];
            end else begin : g_short_ext
                assign imm_short[gi] = ext_bit;
            end
        end
    endgenerate

    assign imm_ext = bus.imm_sel ? imm_long : imm_short;

    // Ready is forced high in reset so upstream never sees a spurious stall.
    assign in_ready = rst || !out_valid_reg || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            out_rd_addr_reg <= '0;
            out_rs_addr_reg <= '0;
            out_rd_reg      <= '0;
            out_rs_reg      <= '0;
            out_imm_reg     <= '0;
            out_inst_reg    <= '0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg   <= 1'b1;
            out_rd_addr_reg <= rd_addr;
            out_rs_addr_reg <= rs_addr;
            out_rd_reg      <= rf_rdata[0];
            out_rs_reg      <= rf_rdata[1];
            out_imm_reg     <= imm_ext;
            out_inst_reg    <= bus.inst;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end else if (out_valid_reg && wb_hit) begin
            // Stalled: keep held operands coherent with late write-backs.
            if (bus.wb_addr == out_rd_addr_reg) begin
                out_rd_reg <= bus.wb_data;
            end
            if (bus.wb_addr == out_rs_addr_reg) begin
                out_rs_reg <= bus.wb_data;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_rd_addr = out_rd_addr_reg;
    assign bus.out_rs_addr = out_rs_addr_reg;
    assign bus.out_rd      = out_rd_reg;
    assign bus.out_rs      = out_rs_reg;
    assign bus.out_imm     = out_imm_reg;
    assign bus.out_inst    = out_inst_reg;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench: two stage configurations (plain / signed+r0-zero) driven in
// lockstep, directed scenarios plus random traffic against a behavioural model.
module tb_id_stage_pipe;
    import cpu_pkg::*;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, imm_sel, flush, wb_we, out_ready;
    logic [15:0] inst, wb_data;
    logic [2:0]  wb_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.CPU_WIDTH(W)) b0 ();
    id_stage_pipe_if #(.CPU_WIDTH(W)) b1 ();

    assign b0.in_valid  = in_valid;
    assign b0.inst      = inst;
    assign b0.imm_sel   = imm_sel;
    assign b0.flush     = flush;
    assign b0.wb_we     = wb_we;
    assign b0.wb_addr   = wb_addr;
    assign b0.wb_data   = wb_data;
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.inst      = inst;
    assign b1.imm_sel   = imm_sel;
    assign b1.flush     = flush;
    assign b1.wb_we     = wb_we;
    assign b1.wb_addr   = wb_addr;
    assign b1.wb_data   = wb_data;
    assign b1.out_ready = out_ready;

    id_stage_pipe #(.CPU_WIDTH(W), .IMM_SIGNED(1'b0), .R0_ZERO(1'b0)) dut0 (
        .clk (clk), .rst (rst), .bus (b0)
    );
    id_stage_pipe #(.CPU_WIDTH(W), .IMM_SIGNED(1'b1), .R0_ZERO(1'b1)) dut1 (
        .clk (clk), .rst (rst), .bus (b1)
    );

    // Reference model; index 1 is the signed-immediate, hardwired-r0 configuration.
    logic [15:0] m_regs [2][8];
    logic        m_valid [2];
    logic [2:0]  m_rd_a [2];
    logic [2:0]  m_rs_a [2];
    logic [15:0] m_rd [2];
    logic [15:0] m_rs [2];
    logic [15:0] m_imm [2];
    logic [15:0] m_inst [2];

    function automatic bit m_wr_ok(int k);
        return wb_we && !(k == 1 && wb_addr == 3'd0);
    endfunction

    function automatic logic [15:0] m_read(int k, logic [2:0] a);
        if (k == 1 && a == 3'd0) return 16'd0;
        if (m_wr_ok(k) && wb_addr == a) return wb_data;
        return m_regs[k][a];
    endfunction

    function automatic logic [15:0] m_imm_of(int k, logic [15:0] i, logic sel);
        int v;
        v = sel ? int'(i[15:8]) : int'(i[15:11]);
        if (k == 1 && i[15]) v = v - (sel ? 256 : 32);
        return 16'(v);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_valid[k] = 1'b0;
                m_rd_a[k] = '0; m_rs_a[k] = '0;
                m_rd[k] = '0; m_rs[k] = '0; m_imm[k] = '0; m_inst[k] = '0;
                for (int r = 0; r < 8; r++) m_regs[k][r] = '0;
            end else begin
                if (flush) begin
                    m_valid[k] = 1'b0;
                end else if (in_valid && (!m_valid[k] || out_ready)) begin
                    m_valid[k] = 1'b1;
                    m_rd_a[k]  = inst[7:5];
                    m_rs_a[k]  = inst[10:8];
                    m_rd[k]    = m_read(k, inst[7:5]);
                    m_rs[k]    = m_read(k, inst[10:8]);
                    m_imm[k]   = m_imm_of(k, inst, imm_sel);
                    m_inst[k]  = inst;
                end else if (out_ready) begin
                    m_valid[k] = 1'b0;
                end else if (m_valid[k] && m_wr_ok(k)) begin
                    if (wb_addr == m_rd_a[k]) m_rd[k] = wb_data;
                    if (wb_addr == m_rs_a[k]) m_rs[k] = wb_data;
                end
                if (m_wr_ok(k)) m_regs[k][wb_addr] = wb_data;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Data fields only matter while the model says the stage holds an instruction.
    function automatic logic [71:0] obs(int k);
        logic v, r;
        logic [2:0] a, b;
        logic [15:0] d, s, im, in;
        if (k == 0) begin
            v = b0.out_valid; r = b0.in_ready; a = b0.out_rd_addr; b = b0.out_rs_addr;
            d = b0.out_rd; s = b0.out_rs; im = b0.out_imm; in = b0.out_inst;
        end else begin
            v = b1.out_valid; r = b1.in_ready; a = b1.out_rd_addr; b = b1.out_rs_addr;
            d = b1.out_rd; s = b1.out_rs; im = b1.out_imm; in = b1.out_inst;
        end
        if (!m_valid[k]) {a, b, d, s, im, in} = '0;
        return {v, r, a, b, d, s, im, in};
    endfunction

    function automatic logic [71:0] expv(int k);
        if (!m_valid[k]) return {1'b0, 1'b1, 70'd0};
        return {1'b1, rst || out_ready, m_rd_a[k], m_rs_a[k], m_rd[k], m_rs[k], m_imm[k], m_inst[k]};
    endfunction

    task automatic idle();
        in_valid = 0; imm_sel = 0; flush = 0; wb_we = 0; out_ready = 1;
        inst = '0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); out_ready = 0;
        tick(); tick();
        checks++;
        if ({b0.out_valid, b0.in_ready, b0.out_rd_addr, b0.out_rs_addr, b0.out_rd, b0.out_rs, b0.out_imm, b0.out_inst} !== {1'b0, 1'b1, 70'd0}) begin
            errors++; $display("FAIL reset_dut0: got valid=%b ready=%b rd=%h rs=%h imm=%h inst=%h, need 0/1/zeros",
                b0.out_valid, b0.in_ready, b0.out_rd, b0.out_rs, b0.out_imm, b0.out_inst);
        end
        checks++;
        if ({b1.out_valid, b1.in_ready, b1.out_rd_addr, b1.out_rs_addr, b1.out_rd, b1.out_rs, b1.out_imm, b1.out_inst} !== {1'b0, 1'b1, 70'd0}) begin
            errors++; $display("FAIL reset_dut1: got valid=%b ready=%b rd=%h rs=%h imm=%h inst=%h, need 0/1/zeros",
                b1.out_valid, b1.in_ready, b1.out_rd, b1.out_rs, b1.out_imm, b1.out_inst);
        end
        rst = 0; tick();
        checks++;
        if ({b0.in_ready, b1.in_ready, b0.out_valid, b1.out_valid} !== 4'b1100) begin
            errors++; $display("FAIL post_reset_idle: got ready=%b%b valid=%b%b, need 11/00",
                b0.in_ready, b1.in_ready, b0.out_valid, b1.out_valid);
        end
        $display("txn reset done");
    endtask

    task automatic test_basic_read();
        idle(); wb_we = 1; wb_addr = 3; wb_data = 16'h1234; tick();
        idle(); in_valid = 1; inst = 16'h0360; tick();
        checks++;
        if ({b0.out_valid, b0.out_rd, b0.out_rs, b1.out_valid, b1.out_rd, b1.out_rs} !== {1'b1, 16'h1234, 16'h1234, 1'b1, 16'h1234, 16'h1234}) begin
            errors++; $display("FAIL basic_read: got v=%b rd=%h rs=%h / v=%b rd=%h rs=%h, need 1 1234 1234",
                b0.out_valid, b0.out_rd, b0.out_rs, b1.out_valid, b1.out_rd, b1.out_rs);
        end
        $display("txn basic read inst=0360");
    endtask

    task automatic test_same_cycle_bypass();
        idle(); in_valid = 1; inst = 16'h0500; wb_we = 1; wb_addr = 5; wb_data = 16'hBEEF; tick();
        idle();
        checks++;
        if ({b0.out_rs, b1.out_rs, b0.out_rs_addr} !== {16'hBEEF, 16'hBEEF, 3'd5}) begin
            errors++; $display("FAIL same_cycle_bypass: got rs=%h/%h addr=%0d, need BEEF/BEEF addr 5",
                b0.out_rs, b1.out_rs, b0.out_rs_addr);
        end
        $display("txn bypass inst=0500");
    endtask

    task automatic test_immediate();
        logic [15:0] t_inst [4] = '{16'hF800, 16'h8000, 16'h7800, 16'h7F00};
        logic        t_sel  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] t_e0   [4] = '{16'h001F, 16'h0080, 16'h000F, 16'h007F};
        logic [15:0] t_e1   [4] = '{16'hFFFF, 16'hFF80, 16'h000F, 16'h007F};
        for (int i = 0; i < 4; i++) begin
            idle(); in_valid = 1; inst = t_inst[i]; imm_sel = t_sel[i]; tick();
            checks++;
            if ({b0.out_imm, b1.out_imm} !== {t_e0[i], t_e1[i]}) begin
                errors++; $display("FAIL immediate_%0d: got %h/%h, need %h/%h",
                    i, b0.out_imm, b1.out_imm, t_e0[i], t_e1[i]);
            end
            $display("txn imm inst=%h sel=%b", t_inst[i], t_sel[i]);
        end
        idle();
    endtask

    task automatic test_stall_refresh();
        idle(); in_valid = 1; inst = 16'h0040; tick();
        in_valid = 1; inst = 16'h1111; out_ready = 0; #1;
        checks++;
        if ({b0.in_ready, b1.in_ready} !== 2'b00) begin
            errors++; $display("FAIL stall_in_ready: got %b%b, need 00", b0.in_ready, b1.in_ready);
        end
        wb_we = 1; wb_addr = 2; wb_data = 16'h00AA; tick();
        wb_we = 0;
        checks++;
        if ({b0.out_valid, b0.out_rd, b0.out_inst, b1.out_valid, b1.out_rd, b1.out_inst} !== {1'b1, 16'h00AA, 16'h0040, 1'b1, 16'h00AA, 16'h0040}) begin
            errors++; $display("FAIL stall_refresh: got v=%b rd=%h inst=%h / v=%b rd=%h inst=%h, need 1 00AA 0040",
                b0.out_valid, b0.out_rd, b0.out_inst, b1.out_valid, b1.out_rd, b1.out_inst);
        end
        out_ready = 1; tick();
        checks++;
        if ({b0.out_valid, b0.out_inst, b1.out_valid, b1.out_inst} !== {1'b1, 16'h1111, 1'b1, 16'h1111}) begin
            errors++; $display("FAIL stall_release: got v=%b inst=%h / v=%b inst=%h, need 1 1111",
                b0.out_valid, b0.out_inst, b1.out_valid, b1.out_inst);
        end
        $display("txn stall refresh then accept inst=1111");
        idle(); tick();
    endtask

    task automatic test_flush();
        idle(); in_valid = 1; inst = 16'h0600; flush = 1; wb_we = 1; wb_addr = 6; wb_data = 16'h7777; tick();
        idle();
        checks++;
        if ({b0.out_valid, b1.out_valid} !== 2'b00) begin
            errors++; $display("FAIL flush_accept: got valid=%b%b, need 00", b0.out_valid, b1.out_valid);
        end
        in_valid = 1; inst = 16'h0600; tick();
        idle();
        checks++;
        if ({b0.out_rs, b1.out_rs} !== {16'h7777, 16'h7777}) begin
            errors++; $display("FAIL flush_wb_persist: got rs=%h/%h, need 7777", b0.out_rs, b1.out_rs);
        end
        $display("txn flush then read r6");
    endtask

    task automatic test_r0_zero();
        idle(); in_valid = 1; inst = 16'h0000; wb_we = 1; wb_addr = 0; wb_data = 16'h5555; tick();
        idle();
        checks++;
        if ({b1.out_rs, b1.out_rd, b0.out_rs} !== {16'h0000, 16'h0000, 16'h5555}) begin
            errors++; $display("FAIL r0_bypass: got r0z rs=%h rd=%h, plain rs=%h, need 0000 0000 5555",
                b1.out_rs, b1.out_rd, b0.out_rs);
        end
        in_valid = 1; inst = 16'h0000; tick();
        idle();
        checks++;
        if ({b1.out_rs, b1.out_rd, b0.out_rd} !== {16'h0000, 16'h0000, 16'h5555}) begin
            errors++; $display("FAIL r0_read: got r0z rs=%h rd=%h, plain rd=%h, need 0000 0000 5555",
                b1.out_rs, b1.out_rd, b0.out_rd);
        end
        $display("txn r0 write and read");
    endtask

    task automatic test_reset_mid_stall();
        idle(); in_valid = 1; inst = 16'h0123; tick();
        in_valid = 1; inst = 16'h0456; out_ready = 0;
        rst = 1; tick();
        checks++;
        if ({b0.out_valid, b0.in_ready, b1.out_valid, b1.in_ready} !== 4'b0101) begin
            errors++; $display("FAIL reset_mid_stall: got v/r=%b%b %b%b, need 01 01",
                b0.out_valid, b0.in_ready, b1.out_valid, b1.in_ready);
        end
        rst = 0; idle(); tick();
        $display("txn reset during stall");
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            inst      = 16'($urandom);
            imm_sel   = 1'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            wb_we     = 1'($urandom);
            wb_addr   = 3'($urandom);
            wb_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if ({b0.in_ready, b1.in_ready} !== {2{rst || !m_valid[0] || out_ready}}) begin
                errors++; $display("FAIL rand_in_ready[%0d]: got %b%b, need %b",
                    n, b0.in_ready, b1.in_ready, rst || !m_valid[0] || out_ready);
            end
            if (!rst && !flush && in_valid && (!m_valid[0] || out_ready))
                $display("txn rand %0d inst=%h sel=%b wb=%b/%0d/%h", n, inst, imm_sel, wb_we, wb_addr, wb_data);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++; $display("FAIL rand_out[%0d] dut%0d: got %h, need %h", n, k, obs(k), expv(k));
                end
            end
        end
        rst = 0; idle(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_basic_read();
        test_same_cycle_bypass();
        test_immediate();
        test_stall_refresh();
        test_flush();
        test_r0_zero();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
